// File: rtl/avl_modport.sv
// ---------------------------------------------------------------------------
// avl_modport
//
// Purpose:
//   Zero-latency Avalon-MM connector between a source (s_*) and a sink (m_*).
//   Every request signal passes straight from s_* to m_*. Every response and
//   backpressure signal passes straight from m_* to s_*. An inline monitor
//   observes the traffic without changing it. The monitor does three things:
//   - tracks the position within a write burst,
//   - counts accepted requests and response cycles,
//   - raises sticky protocol-error flags.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   s_* request inputs       address/read/write/burstcount/writedata/
//                            byteenable/user, forwarded onto m_*
//   m_* response inputs      waitrequest/readdatavalid/readdata/response/
//                            readresponseuser/writeresponse*, forwarded to s_*
//   wr_sop                   next accepted write beat starts a burst
//   wr_bursts_rem            beats remaining after the current write beat
//   rd_req_cnt, wr_beat_cnt  accepted read requests / write beats (mod 2^32)
//   rd_rsp_cnt, wr_rsp_cnt   readdatavalid / writeresponsevalid cycles
//   err_rd_wr                sticky: read and write asserted together
//   err_burst0               sticky: burstcount==0 on a read or a write SOP
// ---------------------------------------------------------------------------
module avl_modport #(
  parameter int ADDR_WIDTH             = 32,
  parameter int DATA_WIDTH             = 512,
  parameter int BURST_CNT_WIDTH        = 7,
  parameter int MASKED_SYMBOL_WIDTH    = 8,
  parameter int RESPONSE_WIDTH         = 2,
  parameter int USER_WIDTH             = 8,
  parameter int WAIT_REQUEST_ALLOWANCE = 0,
  localparam int DATA_N_BYTES          = (DATA_WIDTH + 7) / MASKED_SYMBOL_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset_n,

  // Source side
  input  logic [ADDR_WIDTH-1:0]      s_address,
  input  logic                       s_read,
  input  logic                       s_write,
  input  logic [BURST_CNT_WIDTH-1:0] s_burstcount,
  input  logic [DATA_WIDTH-1:0]      s_writedata,
  input  logic [DATA_N_BYTES-1:0]    s_byteenable,
  input  logic [USER_WIDTH-1:0]      s_user,
  output logic                       s_waitrequest,
  output logic                       s_readdatavalid,
  output logic [DATA_WIDTH-1:0]      s_readdata,
  output logic [RESPONSE_WIDTH-1:0]  s_response,
  output logic [USER_WIDTH-1:0]      s_readresponseuser,
  output logic                       s_writeresponsevalid,
  output logic [RESPONSE_WIDTH-1:0]  s_writeresponse,
  output logic [USER_WIDTH-1:0]      s_writeresponseuser,

  // Sink side
  output logic [ADDR_WIDTH-1:0]      m_address,
  output logic                       m_read,
  output logic                       m_write,
  output logic [BURST_CNT_WIDTH-1:0] m_burstcount,
  output logic [DATA_WIDTH-1:0]      m_writedata,
  output logic [DATA_N_BYTES-1:0]    m_byteenable,
  output logic [USER_WIDTH-1:0]      m_user,
  input  logic                       m_waitrequest,
  input  logic                       m_readdatavalid,
  input  logic [DATA_WIDTH-1:0]      m_readdata,
  input  logic [RESPONSE_WIDTH-1:0]  m_response,
  input  logic [USER_WIDTH-1:0]      m_readresponseuser,
  input  logic                       m_writeresponsevalid,
  input  logic [RESPONSE_WIDTH-1:0]  m_writeresponse,
  input  logic [USER_WIDTH-1:0]      m_writeresponseuser,

  // Monitor
  output logic                       wr_sop,
  output logic [BURST_CNT_WIDTH-1:0] wr_bursts_rem,
  output logic [31:0]                rd_req_cnt,
  output logic [31:0]                wr_beat_cnt,
  output logic [31:0]                rd_rsp_cnt,
  output logic [31:0]                wr_rsp_cnt,
  output logic                       err_rd_wr,
  output logic                       err_burst0
);

  // With a nonzero allowance the sink takes a request even while it asserts
  // waitrequest, so waitrequest no longer gates acceptance.
  localparam bit ALLOW_EN = (WAIT_REQUEST_ALLOWANCE != 32'sd0);

  logic                       w_acc_rd;
  logic                       w_acc_wr;
  logic                       w_burst_zero;
  logic [BURST_CNT_WIDTH-1:0] w_rem_nxt;

  logic [BURST_CNT_WIDTH-1:0] r_bursts_rem;
  logic [31:0]                r_rd_req_cnt;
  logic [31:0]                r_wr_beat_cnt;
  logic [31:0]                r_rd_rsp_cnt;
  logic [31:0]                r_wr_rsp_cnt;
  logic                       r_err_rd_wr;
  logic                       r_err_burst0;

  // Request path: source to sink
  assign m_address    = s_address;
  assign m_read       = s_read;
  assign m_write      = s_write;
  assign m_burstcount = s_burstcount;
  assign m_writedata  = s_writedata;
  assign m_byteenable = s_byteenable;
  assign m_user       = s_user;

  // Response path: sink to source
  assign s_waitrequest        = m_waitrequest;
  assign s_readdatavalid      = m_readdatavalid;
  assign s_readdata           = m_readdata;
  assign s_response           = m_response;
  assign s_readresponseuser   = m_readresponseuser;
  assign s_writeresponsevalid = m_writeresponsevalid;
  assign s_writeresponse      = m_writeresponse;
  assign s_writeresponseuser  = m_writeresponseuser;

  assign w_acc_rd     = s_read  && (!m_waitrequest || ALLOW_EN);
  assign w_acc_wr     = s_write && (!m_waitrequest || ALLOW_EN);
  assign w_burst_zero = (s_burstcount == {BURST_CNT_WIDTH{1'b0}});

  // Burst position after this cycle; a zero burstcount at SOP acts as a
  // single-beat burst, so the remainder stays 0.
  always_comb begin
    w_rem_nxt = r_bursts_rem;
    if (w_acc_wr) begin
      if (wr_sop) begin
        if (w_burst_zero) begin
          w_rem_nxt = {BURST_CNT_WIDTH{1'b0}};
        end else begin
          w_rem_nxt = s_burstcount - {{(BURST_CNT_WIDTH-1){1'b0}}, 1'b1};
        end
      end else begin
        w_rem_nxt = r_bursts_rem - {{(BURST_CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end else begin
      w_rem_nxt = r_bursts_rem;
    end
  end

  // Monitor state: burst tracker, traffic counters and sticky error flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bursts_rem  <= {BURST_CNT_WIDTH{1'b0}};
      r_rd_req_cnt  <= 32'd0;
      r_wr_beat_cnt <= 32'd0;
      r_rd_rsp_cnt  <= 32'd0;
      r_wr_rsp_cnt  <= 32'd0;
      r_err_rd_wr   <= 1'b0;
      r_err_burst0  <= 1'b0;
    end else begin
      r_bursts_rem <= w_rem_nxt;
      if (w_acc_rd) begin
        r_rd_req_cnt <= r_rd_req_cnt + 32'd1;
      end
      if (w_acc_wr) begin
        r_wr_beat_cnt <= r_wr_beat_cnt + 32'd1;
      end
      if (m_readdatavalid) begin
        r_rd_rsp_cnt <= r_rd_rsp_cnt + 32'd1;
      end
      if (m_writeresponsevalid) begin
        r_wr_rsp_cnt <= r_wr_rsp_cnt + 32'd1;
      end
      // Judged on real sink readiness, independent of the allowance.
      if (!m_waitrequest && s_read && s_write) begin
        r_err_rd_wr <= 1'b1;
      end
      if ((w_acc_rd && w_burst_zero) || (w_acc_wr && wr_sop && w_burst_zero)) begin
        r_err_burst0 <= 1'b1;
      end
    end
  end

  assign wr_sop        = (r_bursts_rem == {BURST_CNT_WIDTH{1'b0}});
  assign wr_bursts_rem = r_bursts_rem;
  assign rd_req_cnt    = r_rd_req_cnt;
  assign wr_beat_cnt   = r_wr_beat_cnt;
  assign rd_rsp_cnt    = r_rd_rsp_cnt;
  assign wr_rsp_cnt    = r_wr_rsp_cnt;
  assign err_rd_wr     = r_err_rd_wr;
  assign err_burst0    = r_err_burst0;

endmodule

// File: tb/tb_avl_modport.sv
module tb_avl_modport;

  localparam int AW = 32;
  localparam int DW = 512;
  localparam int BW = 7;
  localparam int NB = 64;
  localparam int RW = 2;
  localparam int UW = 8;

  logic clk;
  logic reset_n;

  logic [AW-1:0] s_address;
  logic          s_read;
  logic          s_write;
  logic [BW-1:0] s_burstcount;
  logic [DW-1:0] s_writedata;
  logic [NB-1:0] s_byteenable;
  logic [UW-1:0] s_user;
  logic          m_waitrequest;
  logic          m_readdatavalid;
  logic [DW-1:0] m_readdata;
  logic [RW-1:0] m_response;
  logic [UW-1:0] m_readresponseuser;
  logic          m_writeresponsevalid;
  logic [RW-1:0] m_writeresponse;
  logic [UW-1:0] m_writeresponseuser;

  // Outputs of the allowance-0 instance (a)
  logic          a_s_waitrequest, a_s_readdatavalid, a_s_writeresponsevalid;
  logic [DW-1:0] a_s_readdata;
  logic [RW-1:0] a_s_response, a_s_writeresponse;
  logic [UW-1:0] a_s_readresponseuser, a_s_writeresponseuser;
  logic [AW-1:0] a_m_address;
  logic          a_m_read, a_m_write;
  logic [BW-1:0] a_m_burstcount;
  logic [DW-1:0] a_m_writedata;
  logic [NB-1:0] a_m_byteenable;
  logic [UW-1:0] a_m_user;
  logic          a_wr_sop, a_err_rd_wr, a_err_burst0;
  logic [BW-1:0] a_wr_bursts_rem;
  logic [31:0]   a_rd_req_cnt, a_wr_beat_cnt, a_rd_rsp_cnt, a_wr_rsp_cnt;

  // Outputs of the allowance-2 instance (b)
  logic          b_s_waitrequest, b_s_readdatavalid, b_s_writeresponsevalid;
  logic [DW-1:0] b_s_readdata;
  logic [RW-1:0] b_s_response, b_s_writeresponse;
  logic [UW-1:0] b_s_readresponseuser, b_s_writeresponseuser;
  logic [AW-1:0] b_m_address;
  logic          b_m_read, b_m_write;
  logic [BW-1:0] b_m_burstcount;
  logic [DW-1:0] b_m_writedata;
  logic [NB-1:0] b_m_byteenable;
  logic [UW-1:0] b_m_user;
  logic          b_wr_sop, b_err_rd_wr, b_err_burst0;
  logic [BW-1:0] b_wr_bursts_rem;
  logic [31:0]   b_rd_req_cnt, b_wr_beat_cnt, b_rd_rsp_cnt, b_wr_rsp_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  avl_modport #(.WAIT_REQUEST_ALLOWANCE(0)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_burstcount(s_burstcount), .s_writedata(s_writedata),
    .s_byteenable(s_byteenable), .s_user(s_user),
    .s_waitrequest(a_s_waitrequest), .s_readdatavalid(a_s_readdatavalid),
    .s_readdata(a_s_readdata), .s_response(a_s_response),
    .s_readresponseuser(a_s_readresponseuser),
    .s_writeresponsevalid(a_s_writeresponsevalid),
    .s_writeresponse(a_s_writeresponse),
    .s_writeresponseuser(a_s_writeresponseuser),
    .m_address(a_m_address), .m_read(a_m_read), .m_write(a_m_write),
    .m_burstcount(a_m_burstcount), .m_writedata(a_m_writedata),
    .m_byteenable(a_m_byteenable), .m_user(a_m_user),
    .m_waitrequest(m_waitrequest), .m_readdatavalid(m_readdatavalid),
    .m_readdata(m_readdata), .m_response(m_response),
    .m_readresponseuser(m_readresponseuser),
    .m_writeresponsevalid(m_writeresponsevalid),
    .m_writeresponse(m_writeresponse),
    .m_writeresponseuser(m_writeresponseuser),
    .wr_sop(a_wr_sop), .wr_bursts_rem(a_wr_bursts_rem),
    .rd_req_cnt(a_rd_req_cnt), .wr_beat_cnt(a_wr_beat_cnt),
    .rd_rsp_cnt(a_rd_rsp_cnt), .wr_rsp_cnt(a_wr_rsp_cnt),
    .err_rd_wr(a_err_rd_wr), .err_burst0(a_err_burst0)
  );

  avl_modport #(.WAIT_REQUEST_ALLOWANCE(2)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_burstcount(s_burstcount), .s_writedata(s_writedata),
    .s_byteenable(s_byteenable), .s_user(s_user),
    .s_waitrequest(b_s_waitrequest), .s_readdatavalid(b_s_readdatavalid),
    .s_readdata(b_s_readdata), .s_response(b_s_response),
    .s_readresponseuser(b_s_readresponseuser),
    .s_writeresponsevalid(b_s_writeresponsevalid),
    .s_writeresponse(b_s_writeresponse),
    .s_writeresponseuser(b_s_writeresponseuser),
    .m_address(b_m_address), .m_read(b_m_read), .m_write(b_m_write),
    .m_burstcount(b_m_burstcount), .m_writedata(b_m_writedata),
    .m_byteenable(b_m_byteenable), .m_user(b_m_user),
    .m_waitrequest(m_waitrequest), .m_readdatavalid(m_readdatavalid),
    .m_readdata(m_readdata), .m_response(m_response),
    .m_readresponseuser(m_readresponseuser),
    .m_writeresponsevalid(m_writeresponsevalid),
    .m_writeresponse(m_writeresponse),
    .m_writeresponseuser(m_writeresponseuser),
    .wr_sop(b_wr_sop), .wr_bursts_rem(b_wr_bursts_rem),
    .rd_req_cnt(b_rd_req_cnt), .wr_beat_cnt(b_wr_beat_cnt),
    .rd_rsp_cnt(b_rd_rsp_cnt), .wr_rsp_cnt(b_wr_rsp_cnt),
    .err_rd_wr(b_err_rd_wr), .err_burst0(b_err_burst0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock and settle 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    s_address = 32'h1234_5678; s_read = 1'b0; s_write = 1'b0;
    s_burstcount = 7'd0; s_writedata = {16{32'hCAFE_F00D}};
    s_byteenable = {NB{1'b1}}; s_user = 8'h5A;
    m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = '0;
    m_response = 2'd0; m_readresponseuser = 8'h00;
    m_writeresponsevalid = 1'b0; m_writeresponse = 2'd0; m_writeresponseuser = 8'h00;
    #2;
    // Reset state, pass-through live during reset
    chk("rst_sop",  a_wr_sop, 1);
    chk("rst_rem",  a_wr_bursts_rem, 0);
    chk("rst_wcnt", a_wr_beat_cnt, 0);
    chk("rst_rcnt", a_rd_req_cnt, 0);
    chk("rst_err1", a_err_rd_wr, 0);
    chk("rst_err2", a_err_burst0, 0);
    chk("pt_addr_rst", a_m_address, 32'h1234_5678);
    #1 reset_n = 1'b1;
    tick();

    // Four-beat write burst
    s_write = 1'b1; s_burstcount = 7'd4; s_address = 32'h0000_0040;
    #1;
    chk("pt_wdata", a_m_writedata, {16{32'hCAFE_F00D}});
    chk("pt_user",  a_m_user, 8'h5A);
    chk("pt_write", a_m_write, 1);
    chk("b0_sop", a_wr_sop, 1);
    tick(); chk("b1_rem", a_wr_bursts_rem, 3); chk("b1_sop", a_wr_sop, 0);
    tick(); chk("b2_rem", a_wr_bursts_rem, 2); chk("b2_sop", a_wr_sop, 0);
    tick(); chk("b3_rem", a_wr_bursts_rem, 1); chk("b3_sop", a_wr_sop, 0);
    tick(); chk("b4_rem", a_wr_bursts_rem, 0); chk("b4_sop", a_wr_sop, 1);
    chk("b4_wcnt", a_wr_beat_cnt, 4);
    chk("b4_wcnt_b", b_wr_beat_cnt, 4);

    // Write held under waitrequest: frozen without allowance, advances with it
    s_burstcount = 7'd2; m_waitrequest = 1'b1;
    #1 chk("pt_waitreq", a_s_waitrequest, 1);
    tick();
    chk("wq_rem_a", a_wr_bursts_rem, 0); chk("wq_cnt_a", a_wr_beat_cnt, 4);
    chk("wq_rem_b", b_wr_bursts_rem, 1); chk("wq_cnt_b", b_wr_beat_cnt, 5);
    tick();
    chk("wq2_cnt_a", a_wr_beat_cnt, 4);
    chk("wq2_rem_b", b_wr_bursts_rem, 0); chk("wq2_cnt_b", b_wr_beat_cnt, 6);

    // Read+write together while stalled: no flag
    s_read = 1'b1; s_burstcount = 7'd1;
    tick();
    chk("rw_stall_err", a_err_rd_wr, 0);
    chk("rw_stall_rcnt", a_rd_req_cnt, 0);
    chk("rw_stall_err_b", b_err_rd_wr, 0);
    chk("rw_stall_rcnt_b", b_rd_req_cnt, 1);
    // Read+write together with the sink ready: flag set, both counted
    m_waitrequest = 1'b0;
    tick();
    chk("rw_err", a_err_rd_wr, 1);
    chk("rw_rcnt", a_rd_req_cnt, 1);
    chk("rw_wcnt", a_wr_beat_cnt, 5);
    s_read = 1'b0; s_write = 1'b0;
    tick();
    chk("rw_err_held", a_err_rd_wr, 1);

    // Write burstcount 0 at SOP behaves as one beat
    s_write = 1'b1; s_burstcount = 7'd0;
    tick();
    s_write = 1'b0;
    chk("wb0_sop", a_wr_sop, 1);
    chk("wb0_rem", a_wr_bursts_rem, 0);
    chk("wb0_wcnt", a_wr_beat_cnt, 6);
    chk("wb0_err", a_err_burst0, 1);

    // Simultaneous read response and write response
    m_readdatavalid = 1'b1; m_writeresponsevalid = 1'b1;
    m_readdata = {16{32'h0BAD_BEEF}}; m_response = 2'd2; m_readresponseuser = 8'h3C;
    m_writeresponse = 2'd1; m_writeresponseuser = 8'hC3;
    #1;
    chk("pt_rdv",   a_s_readdatavalid, 1);
    chk("pt_wrv",   a_s_writeresponsevalid, 1);
    chk("pt_rdata", a_s_readdata, {16{32'h0BAD_BEEF}});
    chk("pt_resp",  a_s_response, 2'd2);
    chk("pt_rruser", a_s_readresponseuser, 8'h3C);
    chk("pt_wresp", a_s_writeresponse, 2'd1);
    chk("pt_wruser", a_s_writeresponseuser, 8'hC3);
    tick();
    m_readdatavalid = 1'b0; m_writeresponsevalid = 1'b0;
    chk("rsp_rcnt", a_rd_rsp_cnt, 1);
    chk("rsp_wcnt", a_wr_rsp_cnt, 1);
    tick();
    chk("rsp_rcnt_idle", a_rd_rsp_cnt, 1);

    // Reset in the middle of a burst
    s_write = 1'b1; s_burstcount = 7'd4;
    tick(); tick();
    chk("mid_rem", a_wr_bursts_rem, 2);
    s_write = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_sop",  a_wr_sop, 1);
    chk("mid_rst_rem",  a_wr_bursts_rem, 0);
    chk("mid_rst_wcnt", a_wr_beat_cnt, 0);
    chk("mid_rst_rsp",  a_rd_rsp_cnt, 0);
    chk("mid_rst_err1", a_err_rd_wr, 0);
    chk("mid_rst_err2", a_err_burst0, 0);
    #1 reset_n = 1'b1;
    tick();

    // Read with burstcount 0
    s_read = 1'b1; s_burstcount = 7'd0;
    tick();
    s_read = 1'b0;
    chk("rb0_err", a_err_burst0, 1);
    chk("rb0_rcnt", a_rd_req_cnt, 1);
    chk("rb0_rwerr", a_err_rd_wr, 0);

    // First write after reset is an SOP
    s_write = 1'b1; s_burstcount = 7'd3;
    #1 chk("post_sop", a_wr_sop, 1);
    tick();
    s_write = 1'b0;
    chk("post_rem", a_wr_bursts_rem, 2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
